// File: rtl/wb_ext_mem_bridge_pkg.sv
// Shared types and constants for the registered Wishbone external-memory bridge.
// Holds the bridge FSM states, Wishbone cycle-type / burst-type encodings and statistics width.
package wb_ext_mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/wb_ext_mem_bridge_if.sv
// Bus bundle for the bridge: Wishbone slave side (wbs_*) and memory master side (mem_*).
// Signal directions are named from the bridge's point of view; "slave" is the bridge modport.
interface wb_ext_mem_bridge_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned MAW = 25
);
    logic [AW-1:0]   wbs_adr_i;
    logic [DW-1:0]   wbs_dat_i;
    logic [DW/8-1:0] wbs_sel_i;
    logic            wbs_we_i;
    logic            wbs_cyc_i;
    logic            wbs_stb_i;
    logic [2:0]      wbs_cti_i;
    logic [1:0]      wbs_bte_i;
    logic [DW-1:0]   wbs_dat_o;
    logic            wbs_ack_o;
    logic            wbs_err_o;
    logic            wbs_rty_o;

    logic [MAW-1:0]  mem_adr_o;
    logic [DW-1:0]   mem_dat_o;
    logic [DW/8-1:0] mem_sel_o;
    logic            mem_we_o;
    logic            mem_cyc_o;
    logic            mem_stb_o;
    logic [2:0]      mem_cti_o;
    logic [1:0]      mem_bte_o;
    logic [DW-1:0]   mem_dat_i;
    logic            mem_ack_i;
    logic            mem_err_i;

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        input  wbs_cti_i, wbs_bte_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o,
        output mem_adr_o, mem_dat_o, mem_sel_o, mem_we_o, mem_cyc_o, mem_stb_o,
        output mem_cti_o, mem_bte_o,
        input  mem_dat_i, mem_ack_i, mem_err_i
    );

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        output wbs_cti_i, wbs_bte_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o,
        input  mem_adr_o, mem_dat_o, mem_sel_o, mem_we_o, mem_cyc_o, mem_stb_o,
        input  mem_cti_o, mem_bte_o,
        output mem_dat_i, mem_ack_i, mem_err_i
    );

endinterface

// File: rtl/wb_sat_counter.sv
// Saturating up-counter: advances by one on each cycle with inc high and sticks at all-ones.
module wb_sat_counter
    import wb_ext_mem_bridge_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: assign the default first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every flop samples the pre-edge value regardless of block order.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_ext_mem_bridge.sv
// Registered Wishbone B3 bridge to an external memory port: one outstanding transfer,
// address-window check, downstream response timeout and saturating error statistics.
module wb_ext_mem_bridge
    import wb_ext_mem_bridge_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MEM_SIZE = 32'h0200_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_ext_mem_bridge_if.slave bus,
    output logic [CNT_W-1:0]   err_cnt_o,
    output logic [CNT_W-1:0]   tmo_cnt_o
);

    localparam int unsigned MAW = $clog2(MEM_SIZE);
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_e         state_q, state_d;
    logic [MAW-1:0] adr_q, adr_d;
    logic [DW-1:0]  wdat_q, wdat_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic           we_q, we_d;
    logic [2:0]     cti_q, cti_d;
    logic [1:0]     bte_q, bte_d;
    logic           req_q, req_d;
    logic [DW-1:0]  rdat_q, rdat_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           tmo_hit;
    logic           out_of_win;

    assign out_of_win = |bus.wbs_adr_i[AW-1:MAW];

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        req_d   = req_q;
        rdat_d  = rdat_q;
        tmo_d   = tmo_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        tmo_hit = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                    if (out_of_win) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        adr_d   = bus.wbs_adr_i[MAW-1:0];
                        wdat_d  = bus.wbs_dat_i;
                        sel_d   = bus.wbs_sel_i;
                        we_d    = bus.wbs_we_i;
                        cti_d   = bus.wbs_cti_i;
                        bte_d   = bus.wbs_bte_i;
                        req_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Priority: master abort, memory error, memory ack, timeout.
                if (!bus.wbs_cyc_i) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (bus.mem_err_i) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if (bus.mem_ack_i) begin
                    if (!we_q) begin
                        rdat_d = bus.mem_dat_i;
                    end
                    req_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    tmo_hit = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cti_q   <= '0;
            bte_q   <= '0;
            req_q   <= 1'b0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            req_q   <= req_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Every error pulse counts; a timeout bumps both counters on the same edge.
    wb_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .inc   (err_d),
        .cnt_o (err_cnt_o)
    );

    wb_sat_counter #(.WIDTH(CNT_W)) u_tmo_cnt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .inc   (tmo_hit),
        .cnt_o (tmo_cnt_o)
    );

    assign bus.wbs_dat_o = rdat_q;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_err_o = err_q;
    assign bus.wbs_rty_o = 1'b0;

    assign bus.mem_adr_o = adr_q;
    assign bus.mem_dat_o = wdat_q;
    assign bus.mem_sel_o = sel_q;
    assign bus.mem_we_o  = we_q;
    assign bus.mem_cyc_o = req_q;
    assign bus.mem_stb_o = req_q;
    assign bus.mem_cti_o = cti_q;
    assign bus.mem_bte_o = bte_q;

endmodule

// File: doc/wb_ext_mem_bridge.md
# wb_ext_mem_bridge

Registered Wishbone B3 bridge between the SoC interconnect memory slot and an off-chip/testbench memory port. It replaces direct wire-through of the memory signals. It adds:
- address window checking against `MEM_SIZE`;
- a single outstanding registered transaction;
- a downstream response timeout that converts a hung memory into a bus error;
- saturating error/timeout statistics.

Data width, address width, memory size and timeout are parametrised.

## Interface
Parameters:
- `AW`, default 32: slave address width.
- `DW`, default 32: data width (multiple of 8); `sel` width is `DW/8`.
- `MEM_SIZE`, default 32'h02000000: window size in bytes, a power of two; `MAW = clog2(MEM_SIZE)`.
- `TIMEOUT`, default 255: cycles to wait for `mem_ack_i`/`mem_err_i`; 0 disables the timeout.

Ports:
- `wb_clk_i` in 1: clock.
- `wb_rst_ni` in 1: reset, asynchronous assert, active-low.
- `wbs_adr_i` in AW; `wbs_dat_i` in DW; `wbs_sel_i` in DW/8; `wbs_we_i`, `wbs_cyc_i`, `wbs_stb_i` in 1; `wbs_cti_i` in 3; `wbs_bte_i` in 2: slave request.
- `wbs_dat_o` out DW; `wbs_ack_o`, `wbs_err_o`, `wbs_rty_o` out 1: slave response. `wbs_rty_o` is tied to 0.
- `mem_adr_o` out MAW; `mem_dat_o` out DW; `mem_sel_o` out DW/8; `mem_we_o`, `mem_cyc_o`, `mem_stb_o` out 1; `mem_cti_o` out 3; `mem_bte_o` out 2: registered memory request.
- `mem_dat_i` in DW; `mem_ack_i`, `mem_err_i` in 1: memory response.
- `err_cnt_o` out 16: saturating count of `wbs_err_o` pulses (all causes).
- `tmo_cnt_o` out 16: saturating count of timeouts.

## Operation
States: IDLE, BUSY, RESP, ERR.
- **IDLE**, on `wbs_cyc_i & wbs_stb_i`:
  - If `wbs_adr_i[AW-1:MAW] != 0` (out of window): go to ERR.
  - Otherwise, register `adr[MAW-1:0]`, `dat`, `sel`, `we`, `cti`, `bte` into the `mem_*` outputs, set `mem_cyc_o`/`mem_stb_o`, clear the timeout counter, and go to BUSY.
- **BUSY**, evaluated in priority order:
  1. `!wbs_cyc_i` (master abort): drop `mem_cyc_o`/`mem_stb_o`, return to IDLE, no response.
  2. `mem_err_i`: drop the memory request, go to ERR. If `mem_ack_i` and `mem_err_i` arrive together, err wins.
  3. `mem_ack_i`: capture `mem_dat_i` into `wbs_dat_o` (reads only; writes leave it unchanged), drop the memory request, go to RESP.
  4. `TIMEOUT != 0` and counter `== TIMEOUT-1`: drop the memory request, increment `tmo_cnt_o`, go to ERR.
  5. Otherwise, increment the counter.
- **RESP**: `wbs_ack_o = 1` for exactly one cycle, then IDLE.
- **ERR**: `wbs_err_o = 1` for exactly one cycle, increment `err_cnt_o`, then IDLE.
- Bursts: `cti`/`bte` are forwarded unchanged. Each beat is an independent bridge transaction; the bridge never generates addresses.
- Counters saturate at 16'hFFFF and never wrap. Both counters increment in the same cycle on a timeout.

## Timing
- Reset values: all outputs 0, state IDLE, both counters 0. Reset asserted mid-transaction drops `mem_cyc_o`/`mem_stb_o` immediately (asynchronously) and issues no response.
- Request is sampled at cycle 0; `mem_stb_o` is high from cycle 1. If `mem_ack_i` is high in cycle k ≥ 1, `wbs_ack_o` is high in cycle k+1. Minimum round trip is 3 cycles.
- An out-of-window request sampled at cycle 0 gives `wbs_err_o` in cycle 1.
- A timeout gives `wbs_err_o` in cycle TIMEOUT+1.
- After RESP/ERR, IDLE samples the next request one cycle later. A B3 classic master that still holds `stb` in the ack cycle is therefore never double-accepted.
- All `wbs_*` and `mem_*` outputs are driven from flops. There are no combinational input-to-output paths.

## Structure
- Package `wb_ext_mem_bridge_pkg`: state enum, CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111), BTE constants, counter width (16).
- One sub-module, `wb_sat_counter` (parametrised width, `inc` input, saturating), instantiated twice.

## Test plan
- Single read, memory acks in the first `mem_stb_o` cycle with `mem_dat_i`=32'hDEADBEEF → `wbs_ack_o` at cycle 2, `wbs_dat_o`=32'hDEADBEEF, `mem_adr_o` = low MAW bits of `wbs_adr_i`.
- Write to 32'h02000010 with default `MEM_SIZE` → `wbs_err_o` at cycle 1, `mem_cyc_o` never asserted, `err_cnt_o`=1.
- `TIMEOUT`=8, memory silent → `mem_stb_o` high for cycles 1–8, `wbs_err_o` at cycle 9, `tmo_cnt_o`=1, `err_cnt_o`=1.
- `mem_ack_i` and `mem_err_i` in the same cycle → `wbs_err_o` pulse only, no `wbs_ack_o`.
- Master drops `wbs_cyc_i` in BUSY cycle 3 → `mem_cyc_o` low next cycle, no ack/err. Async reset asserted during BUSY → all outputs 0 without a clock edge.
- 4-beat INCR burst (`cti` 010, 010, 010, 111) with 1-cycle memory → exactly 4 `wbs_ack_o` pulses, each beat's `cti`/address forwarded. Also drive 70000 error transactions → `err_cnt_o` saturates at 16'hFFFF.
